// File: rtl/crc16_arb.sv
// -----------------------------------------------------------------------------
// crc16_arb
//   Round-robin frame arbiter in front of a single CRC-16 datapath
//   (polynomial x^16+x^15+x^2+1, 16 data bits per step, D[15] first).
//   One requester is granted per frame. Its words are folded into a running
//   CRC, one per cycle, and the final CRC is posted with the owner's index on
//   a valid/ready result port.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  [NREQ]     per-requester word valid
//   i_req_data   [16*NREQ]  per-requester word, requester k at [16k+15:16k]
//   i_req_last   [NREQ]     offered word closes its frame
//   o_req_ready  [NREQ]     word accept, one-hot or zero
//   o_res_valid             result available
//   i_res_ready             result consumed
//   o_res_id     [IW]       owner of the result
//   o_res_crc    [16]       raw CRC register (no reflection, no final XOR)
//   o_res_zero              o_res_crc == 0 (check mode)
// -----------------------------------------------------------------------------
module crc16_arb #(
   parameter int unsigned NREQ = 2,
   parameter logic [15:0] INIT = 16'hFFFF,
   localparam int unsigned IW  = $clog2(NREQ)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NREQ-1:0]      i_req_valid,
   input  logic [16*NREQ-1:0]   i_req_data,
   input  logic [NREQ-1:0]      i_req_last,
   output logic [NREQ-1:0]      o_req_ready,
   output logic                 o_res_valid,
   input  logic                 i_res_ready,
   output logic [IW-1:0]        o_res_id,
   output logic [15:0]          o_res_crc,
   output logic                 o_res_zero
);

   localparam int unsigned DW   = 16;
   localparam logic [15:0] POLY = 16'h8005;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      RESULT = 2'd2
   } state_t;

   // One 16-bit CRC step, MSB of the data word shifted in first
   function automatic logic [15:0] crc16_step(input logic [15:0] d,
                                              input logic [15:0] c);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = DW - 1; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ POLY;
      end
      return r;
   endfunction

   state_t              r_state;
   logic [IW-1:0]       r_ptr;
   logic [IW-1:0]       r_gnt;
   logic [15:0]         r_crc;
   logic [NREQ-1:0]     r_req_ready;
   logic                r_res_valid;
   logic [IW-1:0]       r_res_id;
   logic [15:0]         r_res_crc;
   logic                r_res_zero;

   logic                w_found;
   logic [IW-1:0]       w_idx;
   logic [IW-1:0]       w_ptr_nxt;
   logic [15:0]         w_data;
   logic                w_beat;
   logic                w_last;
   logic [15:0]         w_crc_nxt;

   // Round-robin search: first valid requester at or after r_ptr, with wrap
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         logic [IW-1:0] cand;
         cand = IW'((int'(r_ptr) + k) % int'(NREQ));
         if (!w_found && i_req_valid[cand]) begin
            w_found = 1'b1;
            w_idx   = cand;
         end
      end
   end

   assign w_ptr_nxt = IW'((int'(w_idx) + 1) % int'(NREQ));

   // Granted requester's word and beat qualifiers
   assign w_data    = i_req_data[DW*int'(r_gnt) +: DW];
   assign w_beat    = i_req_valid[r_gnt] & r_req_ready[r_gnt];
   assign w_last    = i_req_last[r_gnt];
   assign w_crc_nxt = crc16_step(w_data, r_crc);

   // Frame controller; every output comes straight from a register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_crc       <= INIT;
         r_req_ready <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_crc   <= '0;
         r_res_zero  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt       <= w_idx;
                  r_ptr       <= w_ptr_nxt;
                  r_crc       <= INIT;
                  r_req_ready <= NREQ'(1) << w_idx;
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               // A dropped valid simply stalls with the CRC held
               if (w_beat) begin
                  r_crc <= w_crc_nxt;
                  if (w_last) begin
                     r_res_crc   <= w_crc_nxt;
                     r_res_zero  <= (w_crc_nxt == 16'h0000);
                     r_res_id    <= r_gnt;
                     r_res_valid <= 1'b1;
                     r_req_ready <= '0;
                     r_state     <= RESULT;
                  end
               end
            end
            RESULT: begin
               if (i_res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_req_ready <= '0;
               r_res_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign o_req_ready = r_req_ready;
   assign o_res_valid = r_res_valid;
   assign o_res_id    = r_res_id;
   assign o_res_crc   = r_res_crc;
   assign o_res_zero  = r_res_zero;

endmodule

// File: tb/tb_crc16_arb.sv
// -----------------------------------------------------------------------------
// tb_crc16_arb
//   Two instances share all inputs: u_dut_a seeds with 16'hFFFF, u_dut_b with
//   16'h0000. Requesters are fed from per-requester word queues; expected
//   results are kept per requester in frame order and compared when each
//   result appears. The reference CRC is polynomial long division.
// -----------------------------------------------------------------------------
module tb_crc16_arb;

   localparam int unsigned NREQ = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [31:0] req_data;
   logic [1:0]  req_last;
   logic        res_ready;

   logic [1:0]  a_req_ready, b_req_ready;
   logic        a_res_valid, b_res_valid;
   logic        a_res_id,    b_res_id;
   logic [15:0] a_res_crc,   b_res_crc;
   logic        a_res_zero,  b_res_zero;

   always #5 clk = ~clk;

   crc16_arb #(.NREQ(NREQ), .INIT(16'hFFFF)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
      .o_req_ready(a_req_ready), .o_res_valid(a_res_valid), .i_res_ready(res_ready),
      .o_res_id(a_res_id), .o_res_crc(a_res_crc), .o_res_zero(a_res_zero)
   );

   crc16_arb #(.NREQ(NREQ), .INIT(16'h0000)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
      .o_req_ready(b_req_ready), .o_res_valid(b_res_valid), .i_res_ready(res_ready),
      .o_res_id(b_res_id), .o_res_crc(b_res_crc), .o_res_zero(b_res_zero)
   );

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;

   // Per-requester stimulus and expectation queues
   logic [15:0] wq [NREQ][$];
   bit          lq [NREQ][$];
   logic [15:0] ea [NREQ][$];
   logic [15:0] eb [NREQ][$];

   bit          lb_pend, acc_pend, hold;
   int          lb_id;
   logic [15:0] h_crc_a, h_crc_b;
   logic        h_id;
   logic [1:0]  prev_ready;
   bit          gnt_log [$];
   int          gnt_cyc [$];

   typedef struct {
      int          id;
      int          n;
      logic [15:0] w [4];
      logic [15:0] exp_a;
      logic [15:0] exp_b;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // CRC step as remainder of ((c ^ d) * x^16) divided by the generator
   function automatic logic [15:0] ref_step(input logic [15:0] c, input logic [15:0] d);
      logic [31:0] v;
      v = {c ^ d, 16'h0000};
      for (int b = 31; b >= 16; b--)
         if (v[b]) v = v ^ (32'h0001_8005 << (b - 16));
      return v[15:0];
   endfunction

   function automatic logic [15:0] ref_frame(input logic [15:0] seed,
                                             input logic [15:0] w [8], input int n);
      logic [15:0] c;
      c = seed;
      for (int i = 0; i < n; i++) c = ref_step(c, w[i]);
      return c;
   endfunction

   task automatic push_frame(input int id, input int n, input logic [15:0] w [8],
                             input logic [15:0] xa, input logic [15:0] xb);
      for (int i = 0; i < n; i++) begin
         wq[id].push_back(w[i]);
         lq[id].push_back(i == n - 1);
      end
      ea[id].push_back(xa);
      eb[id].push_back(xb);
   endtask

   task automatic push_ref(input int id, input int n, input logic [15:0] w [8]);
      push_frame(id, n, w, ref_frame(16'hFFFF, w, n), ref_frame(16'h0000, w, n));
   endtask

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int k = 0; k < int'(NREQ); k++)
         if (wq[k].size() != 0 || ea[k].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < int'(NREQ); k++) begin
         wq[k].delete(); lq[k].delete(); ea[k].delete(); eb[k].delete();
      end
      lb_pend = 0; acc_pend = 0; hold = 0; prev_ready = 2'b00;
   endtask

   // One clock: check outputs, drive inputs from the queues, advance
   task automatic step(input logic [1:0] want, input logic rr);
      logic [1:0] beat;
      chk("ready_onehot", 32'($countones(a_req_ready) <= 1), 32'd1);
      chk("ready_match_b", 32'(b_req_ready), 32'(a_req_ready));
      chk("valid_match_b", 32'(b_res_valid), 32'(a_res_valid));
      if (a_res_valid) chk("ready_in_result", 32'(a_req_ready), 32'd0);
      if (hold) begin
         chk("hold_valid", 32'(a_res_valid), 32'd1);
         chk("hold_crc_a", 32'(a_res_crc), 32'(h_crc_a));
         chk("hold_crc_b", 32'(b_res_crc), 32'(h_crc_b));
         chk("hold_id", 32'(a_res_id), 32'(h_id));
      end
      if (lb_pend) begin
         chk("res_latency", 32'(a_res_valid), 32'd1);
         chk("res_id", 32'(a_res_id), 32'(lb_id));
         chk("res_id_b", 32'(b_res_id), 32'(lb_id));
         if (ea[lb_id].size() == 0) begin
            chk("exp_available", 32'd0, 32'd1);
         end else begin
            logic [15:0] xa, xb;
            xa = ea[lb_id].pop_front();
            xb = eb[lb_id].pop_front();
            chk("res_crc_a", 32'(a_res_crc), 32'(xa));
            chk("res_crc_b", 32'(b_res_crc), 32'(xb));
            chk("res_zero_a", 32'(a_res_zero), 32'(xa == 16'h0000));
            chk("res_zero_b", 32'(b_res_zero), 32'(xb == 16'h0000));
         end
      end
      if (acc_pend) chk("res_drop", 32'(a_res_valid), 32'd0);
      if (prev_ready == 2'b00 && a_req_ready != 2'b00) begin
         gnt_log.push_back(a_req_ready[1]);
         gnt_cyc.push_back(cyc);
      end
      prev_ready = a_req_ready;

      for (int k = 0; k < int'(NREQ); k++) begin
         if (want[k] && wq[k].size() != 0) begin
            req_valid[k]         = 1'b1;
            req_data[16*k +: 16] = wq[k][0];
            req_last[k]          = lq[k][0];
         end else begin
            req_valid[k]         = 1'b0;
            req_data[16*k +: 16] = 16'($urandom);
            req_last[k]          = 1'($urandom);
         end
      end
      res_ready = rr;

      beat    = a_req_ready & req_valid;
      lb_pend = 0;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (beat[k]) begin
            if (lq[k][0]) begin
               lb_pend = 1;
               lb_id   = k;
            end
            void'(wq[k].pop_front());
            void'(lq[k].pop_front());
         end
      end
      acc_pend = a_res_valid && rr;
      hold     = a_res_valid && !rr;
      h_crc_a  = a_res_crc;
      h_crc_b  = b_res_crc;
      h_id     = a_res_id;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Run until every queued frame has produced and handed over its result
   task automatic drain(input int unsigned stall_pct, input int unsigned bp_pct,
                        input int budget);
      int         n;
      logic [1:0] want;
      logic       rr;
      n = 0;
      while (!all_empty() || lb_pend || a_res_valid) begin
         if (n >= budget) begin
            chk("drain_timeout", 32'(n), 32'(budget + 1));
            break;
         end
         for (int k = 0; k < int'(NREQ); k++)
            want[k] = ($urandom_range(99) >= stall_pct);
         rr = ($urandom_range(99) >= bp_pct);
         step(want, rr);
         n++;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready_a"}, 32'(a_req_ready), 32'd0);
      chk({tag, "_valid_a"}, 32'(a_res_valid), 32'd0);
      chk({tag, "_id_a"},    32'(a_res_id),    32'd0);
      chk({tag, "_crc_a"},   32'(a_res_crc),   32'd0);
      chk({tag, "_zero_a"},  32'(a_res_zero),  32'd0);
      chk({tag, "_ready_b"}, 32'(b_req_ready), 32'd0);
      chk({tag, "_valid_b"}, 32'(b_res_valid), 32'd0);
      chk({tag, "_crc_b"},   32'(b_res_crc),   32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t        vecs [4];
      logic [15:0] w [8];
      int          guard;

      rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // Round robin: both requesters continuously valid, two 3-word frames each
      gnt_log.delete(); gnt_cyc.delete();
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
         push_ref(f % 2, 3, w);
      end
      guard = 0;
      while ((!all_empty() || lb_pend || a_res_valid) && guard < 100) begin
         step(2'b11, 1'b1);
         guard++;
      end
      chk("rr_done", 32'(guard < 100), 32'd1);
      chk("rr_grants", 32'(gnt_log.size()), 32'd4);
      if (gnt_log.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("rr_order", 32'(gnt_log[i]), 32'(i % 2));
         for (int i = 0; i < 3; i++) chk("rr_period", 32'(gnt_cyc[i+1] - gnt_cyc[i]), 32'd5);
      end

      // Table vectors: single-word frames and a two-word frame
      vecs[0] = '{id: 0, n: 1, w: '{16'h0000, 16'h0, 16'h0, 16'h0}, exp_a: 16'h800D, exp_b: 16'h0000};
      vecs[1] = '{id: 0, n: 1, w: '{16'h0001, 16'h0, 16'h0, 16'h0}, exp_a: 16'h0008, exp_b: 16'h8005};
      vecs[2] = '{id: 1, n: 2, w: '{16'h0001, 16'h0000, 16'h0, 16'h0}, exp_a: 16'h0, exp_b: 16'h0};
      vecs[3] = '{id: 1, n: 1, w: '{16'h0000, 16'h0, 16'h0, 16'h0}, exp_a: 16'h800D, exp_b: 16'h0000};
      for (int i = 0; i < 8; i++) w[i] = (i < 4) ? vecs[2].w[i] : 16'h0;
      vecs[2].exp_a = ref_frame(16'hFFFF, w, 2);
      vecs[2].exp_b = ref_frame(16'h0000, w, 2);
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 8; i++) w[i] = (i < 4) ? vecs[v].w[i] : 16'h0;
         push_frame(vecs[v].id, vecs[v].n, w, vecs[v].exp_a, vecs[v].exp_b);
         step(2'(1 << vecs[v].id), 1'b1);
         chk("grant_latency", 32'(a_req_ready), 32'(1 << vecs[v].id));
         drain(0, 0, 20);
      end

      // Stall: requester 1 drops valid for 4 cycles after two beats
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      push_ref(1, 4, w);
      step(2'b10, 1'b1);
      step(2'b10, 1'b1);
      step(2'b10, 1'b1);
      chk("stall_two_beats", 32'(wq[1].size()), 32'd2);
      for (int s = 0; s < 4; s++) begin
         step(2'b00, 1'b1);
         chk("stall_ready_held", 32'(a_req_ready), 32'b10);
      end
      drain(0, 0, 30);

      // Backpressure: result held 5 cycles while another requester waits
      w[0] = 16'h1234; push_ref(0, 1, w);
      w[0] = 16'hBEEF; push_ref(1, 1, w);
      guard = 0;
      while (!a_res_valid && guard < 10) begin
         step(2'b11, 1'b0);
         guard++;
      end
      chk("bp_result_seen", 32'(a_res_valid), 32'd1);
      for (int s = 0; s < 5; s++) begin
         step(2'b11, 1'b0);
         chk("bp_valid_held", 32'(a_res_valid), 32'd1);
         chk("bp_no_grant", 32'(a_req_ready), 32'd0);
      end
      drain(0, 0, 30);

      // Randomised traffic with stalls and result backpressure
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
         push_ref(int'($urandom_range(1)), int'($urandom_range(6, 1)), w);
      end
      drain(25, 30, 4000);

      // Reset after 2 of 4 words from requester 0 (leaves ptr at 1 if not reset)
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      push_ref(0, 4, w);
      guard = 0;
      while (wq[0].size() > 2 && guard < 10) begin
         step(2'b01, 1'b1);
         guard++;
      end
      chk("rst_two_beats", 32'(wq[0].size()), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      req_valid = '0;
      clear_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step(2'b00, 1'b1);
         chk("rst_no_result", 32'(a_res_valid), 32'd0);
      end
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      push_ref(0, 2, w);
      push_ref(1, 2, w);
      step(2'b11, 1'b1);
      chk("rst_ptr_zero", 32'(a_req_ready), 32'b01);
      drain(0, 0, 40);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/crc16_arb.md
# crc16_arb

Frame-level controller that shares one `crc16` datapath between `NREQ` streaming requesters, for example the network-interface links. The datapath uses polynomial x^16+x^15+x^2+1, 16-bit data per step, and the first serial bit is D[15]. The block grants one requester at a time on a round-robin basis and holds the grant for a whole frame. It accumulates one data word per cycle into a running CRC register, then posts the final CRC together with the requester ID on a result port that has a valid/ready handshake.

## Interface
- `NREQ`, default 2: number of requesters (≥2). `IW` = `$clog2(NREQ)`.
- `INIT`, default 16'hFFFF: CRC seed loaded at the start of every frame.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  NREQ  per-requester word valid.
- `i_req_data`  in  16*NREQ  per-requester word; requester k uses bits [16k+15:16k].
- `i_req_last`  in  NREQ  the word being offered is the last word of its frame.
- `o_req_ready`  out  NREQ  per-requester word accept; one-hot or zero.
- `o_res_valid`  out  1  result available.
- `i_res_ready`  in  1  consumer accepts the result.
- `o_res_id`  out  IW  index of the requester that owns the result.
- `o_res_crc`  out  16  final CRC of the frame. It is the raw register value: no reflection and no final XOR.
- `o_res_zero`  out  1  `o_res_crc == 0`. This serves the check mode, where the frame already carries its own CRC.

## Operation
- **State machine:** states `IDLE`, `BUSY` and `RESULT`; registered state.
- **IDLE:**
  - `o_req_ready` = 0.
  - If any `i_req_valid` bit is set, grant the first requester with valid set, searching from round-robin pointer `ptr` upward with wrap.
  - On a grant: `gnt` ← that index; `ptr` ← (index+1) mod NREQ; `crc` ← `INIT`; next state `BUSY`.
  - If no valid bit is set, stay in `IDLE`.
- **BUSY:**
  - `o_req_ready[gnt]` = 1; all other ready bits are 0.
  - On each beat (`i_req_valid[gnt] & o_req_ready[gnt]`): `crc` ← `crc16(data[gnt], crc)`.
  - If the beat has `i_req_last[gnt]` set: capture the updated CRC into the result register, set `o_res_id` ← `gnt`, and go to `RESULT`.
  - If `i_req_valid[gnt]` drops, the block stalls with `crc` held. There is no timeout.
  - Valid from any other requester is ignored until the frame ends.
- **RESULT:**
  - `o_req_ready` = 0; `o_res_valid` = 1.
  - `o_res_id`, `o_res_crc` and `o_res_zero` stay stable until `i_res_ready` is 1.
  - When `i_res_ready` is 1, go to `IDLE`.
- **Single-word frames:** a frame whose first beat carries `last` is legal.
- **Output decode:** `o_req_ready` and `o_res_valid` are decoded from registered state only. There is no combinational path from `i_req_valid` or `i_res_ready` to any output.
- **Reset:**
  - State `IDLE`, `ptr` = 0, `gnt` = 0, `crc` = `INIT`.
  - Outputs: `o_req_ready` = 0, `o_res_valid` = 0, `o_res_id` = 0, `o_res_crc` = 0, `o_res_zero` = 0.
  - Reset asserted mid-frame or mid-result discards the partial CRC and any pending result. No result is emitted for that frame.

## Timing
- **Grant:** the cycle after `IDLE` sees valid, the block is in `BUSY` and `o_req_ready[gnt]` = 1. The first word is accepted no earlier than cycle 1 after valid first appears in `IDLE`.
- **Throughput:** 1 word per cycle inside a frame.
- **Result latency:** `o_res_valid` rises 1 cycle after the `last` beat.
- **Frame overhead:** minimum 2 idle cycles between the `last` beat of one frame and the first beat of the next frame. One cycle is `RESULT` with same-cycle `i_res_ready`, and one is `IDLE`.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.

## Test plan
- **Single word, default seed:** `INIT`=16'hFFFF, requester 0 sends one word 16'h0000 with `last`.
  - Required: `o_res_valid` rises 1 cycle after the beat, with `o_res_crc`=16'h800D, `o_res_id`=0, `o_res_zero`=0.
  - Repeat with data 16'h0001: required `o_res_crc`=16'h0008.
- **Polynomial and zero flag:** `INIT`=0.
  - Data 16'h0001 → `o_res_crc`=16'h8005.
  - Data 16'h0000 → `o_res_crc`=16'h0000 with `o_res_zero`=1.
  - Two-word frame {16'h0001, 16'h0000} → equals a software model of the CRC; the bench checks against its reference function.
- **Round robin:** both requesters hold valid continuously, each sending 3-word frames.
  - Required: grant order 0,1,0,1.
  - `o_req_ready` is never asserted for more than one requester at a time, and is never asserted in `RESULT` or `IDLE`.
  - Each frame takes 3 busy cycles plus ≥2 overhead cycles.
- **Stall and backpressure:**
  - Requester 1 drops valid for 4 cycles mid-frame. Required: `crc` is held, and the final result equals the no-gap result.
  - Hold `i_res_ready`=0 for 5 cycles. Required: the result fields are stable and no new grant is issued.
- **Reset mid-frame:** assert `i_rst_n`=0 after 2 of 4 words.
  - Required: all outputs are at their reset values immediately on assertion, and no result is produced.
  - After release, a fresh frame from requester 1 is granted first only if requester 0 is idle. `ptr` restarts at 0.
